beat_sequencer: RTL
===================

Name: beat_sequencer

Overview:
- Parametrised successor to the fixed six-beat ring counter in the 8-bit CPU.
- Generates one-hot T-state strobes consumed by control_unit, pc and ir.
- Adds a configurable beat count and variable-length instructions (early end).
- Adds run/stop, HLT latching, single-step debug mode and an instruction counter.

Parameters:
NUM_BEATS, 6, T-states per full instruction (minimum 2)
FETCH_BEATS, 3, leading beats during which end_early is ignored (1 to NUM_BEATS-1)
CNT_W, 8, width of instruction counter
IDX_W, 3, width of beat_idx (must be at least clog2(NUM_BEATS))

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  level; 1 = execute, 0 = stop at next instruction boundary
step_mode  input  1  1 = beats advance only on step rising edges
step  input  1  synchronous step request, edge-detected internally
end_early  input  1  current instruction finishes after this beat
halt_req  input  1  HLT decoded; stop permanently at instruction boundary
t  output  NUM_BEATS  one-hot T-state strobe, t[0]=T0; all-zero when not running
beat_idx  output  IDX_W  binary index of the active beat
instr_start  output  1  high during the first T0 cycle of each instruction
instr_count  output  CNT_W  completed instructions, wraps modulo 2^CNT_W
running  output  1  high in RUN
halted  output  1  high in HALTED

Behaviour:
- Reset (rst=0, async, immediate):
  - state IDLE; t=0; beat_idx=0; instr_start=0; instr_count=0; running=0; halted=0.
  - halt_pend=0; step edge register=0.
- States: IDLE, RUN, HALTED. Outputs are registered.
- adv = step_mode ? (step & ~step_q) : 1. step_q is step delayed one cycle.
- IDLE:
  - t=0.
  - run=1 at an edge -> RUN, t=one-hot T0, beat_idx=0, instr_start=1. This transition ignores adv.
- RUN, edge with adv=0:
  - All outputs hold.
  - instr_start clears after its first cycle.
- RUN, edge with adv=1, beat_idx=b:
  - boundary = (b==NUM_BEATS-1) | (end_early & b>=FETCH_BEATS).
  - Not boundary: b+1, t shifts left one place, instr_start=0.
  - Boundary: instr_count+1 (wrap), then the first matching rule below applies.
    - halt_pend | halt_req -> HALTED, t=0, halted=1, running=0.
    - run=0 -> IDLE, t=0, running=0.
    - Otherwise -> T0, beat_idx=0, instr_start=1.
- halt_req:
  - Sampled every RUN cycle, regardless of adv.
  - Sets sticky halt_pend.
  - Asserted on the boundary beat itself, it halts at that boundary.
- end_early at b<FETCH_BEATS is ignored. end_early on the last beat behaves the same as a normal wrap.
- HALTED:
  - t=0; outputs frozen.
  - Only rst exits. run, step and end_early are ignored.
- step_mode changes take effect at the next edge. A held step produces exactly one advance.
- In step mode the IDLE->RUN transition needs no step. The following beats do.
- Exactly one bit of t is high in RUN; t=0 in IDLE and HALTED at all times.
- Reset asserted mid-instruction returns to IDLE immediately. No partial instruction is counted.

Test Plan:
- Free-run: rst low then high; run=1, NUM_BEATS=6.
  - Required: t sequence 000001,000010, ... ,100000,000001.
  - Required: instr_start high every 6th cycle; instr_count=3 after 18 beats.
- Early end: end_early pulsed at beat 1, then at beat 3.
  - Beat 1 pulse: ignored.
  - Beat 3 pulse: next beat is T0 and instr_count increments. Instruction length is 4 cycles.
- Halt: halt_req pulsed at beat 2.
  - Required: beats 3-5 complete, then t=0 and halted=1, instr_count+1.
  - Required: run toggles and step pulses cause no change until rst.
- Stop/restart:
  - run dropped at beat 1 -> IDLE after beat 5, t=0, running=0.
  - run=1 again -> T0 with instr_start=1 on the next edge.
- Single step: step_mode=1, step held high 5 cycles, then 3 separate 1-cycle pulses.
  - Required: held step gives 1 advance; the pulses give 3 more advances; otherwise t is stable.
- Async reset mid-beat 4 (between clock edges):
  - Required: outputs reset immediately without a clock edge.
  - Required: instr_count=0; recovery to T0 on the first edge after release with run=1.

Source files
------------

// File: rtl/beat_sequencer.sv
// T-state sequencer: one-hot beat strobes with early end, run/stop, halt latching,
// single-step advance and a completed-instruction counter.
module beat_sequencer #(
    parameter int NUM_BEATS   = 6,
    parameter int FETCH_BEATS = 3,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 end_early,
    input  logic                 halt_req,
    output logic [NUM_BEATS-1:0] t,
    output logic [IDX_W-1:0]     beat_idx,
    output logic                 instr_start,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 running,
    output logic                 halted
);

    // state  | meaning
    // IDLE   | stopped at an instruction boundary, t all-zero
    // RUN    | stepping through beats, exactly one t bit high
    // HALTED | HLT retired; frozen until reset

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BEATS - 1);
    localparam logic [IDX_W-1:0] FETCH_IDX = IDX_W'(FETCH_BEATS);

    state_t                 state, state_nxt;
    logic                   step_q, halt_pend;
    logic                   adv, boundary, halt_now;
    logic [NUM_BEATS-1:0]   t_nxt;
    logic [IDX_W-1:0]       idx_nxt;
    logic                   start_nxt;
    logic [CNT_W-1:0]       count_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            step_q      <= 1'b0;
            halt_pend   <= 1'b0;
            t           <= '0;
            beat_idx    <= '0;
            instr_start <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            step_q      <= step;
            if (state == RUN && halt_req)
                halt_pend <= 1'b1;
            t           <= t_nxt;
            beat_idx    <= idx_nxt;
            instr_start <= start_nxt;
            instr_count <= count_nxt;
        end
    end

    always_comb begin
        adv       = step_mode ? (step & ~step_q) : 1'b1;
        boundary  = (beat_idx == LAST_IDX) | (end_early & (beat_idx >= FETCH_IDX));
        halt_now  = halt_pend | halt_req;
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = RUN;
            RUN: begin
                if (adv && boundary) begin
                    if (halt_now)  state_nxt = HALTED;
                    else if (!run) state_nxt = IDLE;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        t_nxt     = t;
        idx_nxt   = beat_idx;
        start_nxt = 1'b0;
        count_nxt = instr_count;
        case (state)
            IDLE: begin
                if (run) begin
                    t_nxt     = NUM_BEATS'(1);
                    idx_nxt   = '0;
                    start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (adv) begin
                    if (!boundary) begin
                        t_nxt   = t << 1;
                        idx_nxt = beat_idx + IDX_W'(1);
                    end else begin
                        count_nxt = instr_count + CNT_W'(1);
                        idx_nxt   = '0;
                        if (state_nxt == RUN) begin
                            t_nxt     = NUM_BEATS'(1);
                            start_nxt = 1'b1;
                        end else begin
                            t_nxt = '0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign running = (state == RUN);
    assign halted  = (state == HALTED);

endmodule
